wb_retire_unit: RTL and testbench

//  Parametrised writeback/retire stage: owns the MEM/WB pipeline register, selects result
//  (ALU / memory / link PC), drives the register-file write port and the WB forwarding bus.

---
 rtl/wb_retire_unit_pkg.sv | 46 ++++
 rtl/wb_retire_unit_pipe_reg.sv | 83 ++++++++
 rtl/wb_retire_unit.sv | 114 +++++++++++
 tb/tb_wb_retire_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_retire_unit_pkg.sv
// Shared definitions for the writeback/retire stage: result-select encodings,
// W-register control fields and the bubble constant used by the memory stage too.
package wb_retire_unit_pkg;

    // Result source select carried down the pipe with each instruction
    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_LINK = 2'b10,
        RES_RSVD = 2'b11
    } res_sel_e;

    // Control part of the W register; data fields are parametrised separately
    typedef struct packed {
        logic     valid;
        logic     halt;
        logic     reg_wr;
        res_sel_e res_sel;
    } w_ctrl_t;

    localparam int W_CTRL_BITS = $bits(w_ctrl_t);

    // A bubble retires nothing: not valid, no write, no halt
    localparam w_ctrl_t W_CTRL_BUBBLE = '{
        valid:   1'b0,
        halt:    1'b0,
        reg_wr:  1'b0,
        res_sel: RES_ALU
    };

    // Pack loose memory-stage control bits into the W control struct
    function automatic w_ctrl_t pack_ctrl(
        input logic       valid,
        input logic       halt,
        input logic       reg_wr,
        input logic [1:0] sel
    );
        w_ctrl_t c;
        c.valid   = valid;
        c.halt    = halt;
        c.reg_wr  = reg_wr;
        c.res_sel = res_sel_e'(sel);
        return c;
    endfunction

endpackage

// File: rtl/wb_retire_unit_pipe_reg.sv
// MEM/WB pipeline register with stall hold, flush-to-bubble and the fired bit
// that makes a stalled entry retire only on its first presented cycle.
module wb_retire_unit_pipe_reg
    import wb_retire_unit_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  w_ctrl_t           ctrl_i,
    input  logic [REG_AW-1:0] dst_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] mem_i,
    input  logic [DATA_W-1:0] link_i,
    output w_ctrl_t           ctrl_o,
    output logic [REG_AW-1:0] dst_o,
    output logic [DATA_W-1:0] alu_o,
    output logic [DATA_W-1:0] mem_o,
    output logic [DATA_W-1:0] link_o,
    output logic              fired_o
);

    w_ctrl_t           ctrl_q, ctrl_d;
    logic [REG_AW-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] mem_q, mem_d;
    logic [DATA_W-1:0] link_q, link_d;
    logic              fired_q, fired_d;

    // Next-state: flush wins over stall; any new load re-arms the fired bit
    always_comb begin
        ctrl_d  = ctrl_q;
        dst_d   = dst_q;
        alu_d   = alu_q;
        mem_d   = mem_q;
        link_d  = link_q;
        fired_d = fired_q;
        if (flush_i) begin
            ctrl_d  = W_CTRL_BUBBLE;
            fired_d = 1'b0;
        end else if (!stall_i) begin
            ctrl_d  = ctrl_i;
            dst_d   = dst_i;
            alu_d   = alu_i;
            mem_d   = mem_i;
            link_d  = link_i;
            fired_d = 1'b0;
        end else begin
            // Held entry: once presented while valid it has had its one chance to retire
            fired_d = fired_q | ctrl_q.valid;
        end
    end

    // W register state, cleared to a zero-data bubble on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= W_CTRL_BUBBLE;
            dst_q   <= {REG_AW{1'b0}};
            alu_q   <= {DATA_W{1'b0}};
            mem_q   <= {DATA_W{1'b0}};
            link_q  <= {DATA_W{1'b0}};
            fired_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            dst_q   <= dst_d;
            alu_q   <= alu_d;
            mem_q   <= mem_d;
            link_q  <= link_d;
            fired_q <= fired_d;
        end
    end

    assign ctrl_o  = ctrl_q;
    assign dst_o   = dst_q;
    assign alu_o   = alu_q;
    assign mem_o   = mem_q;
    assign link_o  = link_q;
    assign fired_o = fired_q;

endmodule

// File: rtl/wb_retire_unit.sv
// Writeback/retire stage: result select, register-file write port, WB forwarding
// bus, sticky halt latch and retired-instruction counter.
module wb_retire_unit
    import wb_retire_unit_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_valid,
    input  logic              m_halt,
    input  logic              m_reg_wr,
    input  logic [1:0]        m_res_sel,
    input  logic [REG_AW-1:0] m_dst,
    input  logic [DATA_W-1:0] m_alu,
    input  logic [DATA_W-1:0] m_mem,
    input  logic [DATA_W-1:0] m_link,
    input  logic              wb_stall,
    input  logic              wb_flush,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wr_reg,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              fwd_valid,
    output logic              halt_W,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_cnt
);

    w_ctrl_t           w_ctrl_s;
    logic [REG_AW-1:0] w_dst_s;
    logic [DATA_W-1:0] w_alu_s, w_mem_s, w_link_s;
    logic              w_fired_s;
    logic              ret_s;
    logic [DATA_W-1:0] res_s;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    wb_retire_unit_pipe_reg #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_pipe_reg (
        .clk     (clk),
        .rst     (rst),
        .stall_i (wb_stall),
        .flush_i (wb_flush),
        .ctrl_i  (pack_ctrl(m_valid, m_halt, m_reg_wr, m_res_sel)),
        .dst_i   (m_dst),
        .alu_i   (m_alu),
        .mem_i   (m_mem),
        .link_i  (m_link),
        .ctrl_o  (w_ctrl_s),
        .dst_o   (w_dst_s),
        .alu_o   (w_alu_s),
        .mem_o   (w_mem_s),
        .link_o  (w_link_s),
        .fired_o (w_fired_s)
    );

    // An entry retires once: valid, not yet fired, and the core has not halted
    assign ret_s = w_ctrl_s.valid & ~w_fired_s & ~halted_q;

    // Result select; the reserved code falls back to the ALU result
    always_comb begin
        res_s = w_alu_s;
        case (w_ctrl_s.res_sel)
            RES_ALU:  res_s = w_alu_s;
            RES_MEM:  res_s = w_mem_s;
            RES_LINK: res_s = w_link_s;
            RES_RSVD: res_s = w_alu_s;
            default:  res_s = w_alu_s;
        endcase
    end

    // Write port: r0 is hard zero and HLT never writes, whatever its reg_wr says
    assign rf_we      = ret_s & w_ctrl_s.reg_wr & ~w_ctrl_s.halt & (w_dst_s != {REG_AW{1'b0}});
    assign rf_wr_reg  = w_dst_s;
    assign rf_wr_data = res_s;
    assign fwd_valid  = rf_we;
    assign halt_W     = ret_s & w_ctrl_s.halt;

    // Halt latch and counter next-state; counter wraps freely
    always_comb begin
        halted_d = halted_q;
        cnt_d    = cnt_q;
        if (ret_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_ctrl_s.halt) begin
                halted_d = 1'b1;
            end else begin
                halted_d = halted_q;
            end
        end else begin
            cnt_d    = cnt_q;
            halted_d = halted_q;
        end
    end

    // Sticky halt and retire counter, only cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign halted      = halted_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_wb_retire_unit.sv
// Self-checking bench for wb_retire_unit: directed scenarios plus randomized
// traffic against an instruction-level retire model.
module tb_wb_retire_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_valid = 1'b0, m_halt = 1'b0, m_reg_wr = 1'b0;
    logic [1:0]  m_res_sel = 2'b00;
    logic [3:0]  m_dst = 4'h0;
    logic [15:0] m_alu = 16'h0, m_mem = 16'h0, m_link = 16'h0;
    logic        wb_stall = 1'b0, wb_flush = 1'b0;

    logic        rf_we, fwd_valid, halt_W, halted;
    logic [3:0]  rf_wr_reg;
    logic [15:0] rf_wr_data;
    logic [31:0] retired_cnt;

    logic        rf_we4, fwd_valid4, halt_W4, halted4;
    logic [3:0]  rf_wr_reg4;
    logic [15:0] rf_wr_data4;
    logic [3:0]  retired_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_retire_unit u_dut (
        .clk(clk), .rst(rst), .m_valid(m_valid), .m_halt(m_halt), .m_reg_wr(m_reg_wr),
        .m_res_sel(m_res_sel), .m_dst(m_dst), .m_alu(m_alu), .m_mem(m_mem), .m_link(m_link),
        .wb_stall(wb_stall), .wb_flush(wb_flush), .rf_we(rf_we), .rf_wr_reg(rf_wr_reg),
        .rf_wr_data(rf_wr_data), .fwd_valid(fwd_valid), .halt_W(halt_W), .halted(halted),
        .retired_cnt(retired_cnt)
    );

    wb_retire_unit #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .m_valid(m_valid), .m_halt(m_halt), .m_reg_wr(m_reg_wr),
        .m_res_sel(m_res_sel), .m_dst(m_dst), .m_alu(m_alu), .m_mem(m_mem), .m_link(m_link),
        .wb_stall(wb_stall), .wb_flush(wb_flush), .rf_we(rf_we4), .rf_wr_reg(rf_wr_reg4),
        .rf_wr_data(rf_wr_data4), .fwd_valid(fwd_valid4), .halt_W(halt_W4), .halted(halted4),
        .retired_cnt(retired_cnt4)
    );

    // Reference model: the instruction sitting in writeback and whether it already retired
    typedef struct {
        logic        valid, halt, wr;
        logic [1:0]  sel;
        logic [3:0]  dst;
        logic [15:0] alu, mem, link;
    } instr_t;

    instr_t      mdl_w;
    logic        mdl_done;
    logic        mdl_halted;
    logic [31:0] mdl_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic mdl_active();
        return mdl_w.valid && !mdl_done && !mdl_halted;
    endfunction

    function automatic logic mdl_we();
        return mdl_active() && mdl_w.wr && !mdl_w.halt && (mdl_w.dst != 4'h0);
    endfunction

    function automatic logic [15:0] mdl_data();
        if (mdl_w.sel == 2'd1) return mdl_w.mem;
        if (mdl_w.sel == 2'd2) return mdl_w.link;
        return mdl_w.alu;
    endfunction

    task automatic mdl_reset();
        mdl_w      = '{valid:1'b0, halt:1'b0, wr:1'b0, sel:2'b00, dst:4'h0,
                       alu:16'h0, mem:16'h0, link:16'h0};
        mdl_done   = 1'b0;
        mdl_halted = 1'b0;
        mdl_cnt    = 32'd0;
    endtask

    task automatic check_outputs();
        logic exp_we;
        exp_we = mdl_we();
        check("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
        check("fwd_valid", {31'd0, fwd_valid}, {31'd0, exp_we});
        check("halt_W", {31'd0, halt_W}, {31'd0, mdl_active() && mdl_w.halt});
        check("halted", {31'd0, halted}, {31'd0, mdl_halted});
        check("retired_cnt", retired_cnt, mdl_cnt);
        check("retired_cnt4", {28'd0, retired_cnt4}, {28'd0, mdl_cnt[3:0]});
        check("halted4", {31'd0, halted4}, {31'd0, mdl_halted});
        if (exp_we) begin
            check("rf_wr_reg", {28'd0, rf_wr_reg}, {28'd0, mdl_w.dst});
            check("rf_wr_data", {16'd0, rf_wr_data}, {16'd0, mdl_data()});
        end
    endtask

    // One clock: apply inputs, advance the model across the edge, check just after it
    task automatic step(input logic v, input logic h, input logic w, input logic [1:0] sel,
                        input logic [3:0] dst, input logic [15:0] alu, input logic [15:0] mem,
                        input logic [15:0] link, input logic st, input logic fl);
        m_valid = v; m_halt = h; m_reg_wr = w; m_res_sel = sel; m_dst = dst;
        m_alu = alu; m_mem = mem; m_link = link; wb_stall = st; wb_flush = fl;
        @(posedge clk);
        if (mdl_active()) begin
            mdl_cnt  = mdl_cnt + 32'd1;
            mdl_done = 1'b1;
            if (mdl_w.halt) mdl_halted = 1'b1;
        end
        if (fl) begin
            mdl_w.valid = 1'b0; mdl_w.halt = 1'b0; mdl_w.wr = 1'b0;
            mdl_done = 1'b0;
        end else if (!st) begin
            mdl_w = '{valid:v, halt:h, wr:w, sel:sel, dst:dst, alu:alu, mem:mem, link:link};
            mdl_done = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic st);
        step(1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 16'h0, 16'h0, st, 1'b0);
    endtask

    task automatic add(input logic [3:0] dst, input logic [15:0] val);
        step(1'b1, 1'b0, 1'b1, 2'b00, dst, val, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    // Async reset applied mid-cycle; all outputs must clear immediately
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        mdl_reset();
        check_outputs();
        check("rst_reg", {28'd0, rf_wr_reg}, 32'd0);
        check("rst_data", {16'd0, rf_wr_data}, 32'd0);
        m_valid = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        mdl_reset();
        do_reset();

        // ADD r3 = 0x1234
        add(4'd3, 16'h1234);
        check("add_we", {31'd0, rf_we}, 32'd1);
        check("add_reg", {28'd0, rf_wr_reg}, 32'd3);
        check("add_data", {16'd0, rf_wr_data}, 32'h1234);
        idle(1'b0);
        check("add_cnt", retired_cnt, 32'd1);

        // Load r5 from memory, then held by stall for 3 clocks: one write only
        step(1'b1, 1'b0, 1'b1, 2'b01, 4'd5, 16'h1111, 16'hBEEF, 16'h2222, 1'b0, 1'b0);
        check("ld_data", {16'd0, rf_wr_data}, 32'hBEEF);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check("ld_stall_we", {31'd0, rf_we}, 32'd0);
        end
        check("ld_cnt", retired_cnt, 32'd2);

        // Write to r0: no write, still counts
        add(4'd0, 16'hFFFF);
        check("r0_we", {31'd0, rf_we}, 32'd0);
        check("r0_fwd", {31'd0, fwd_valid}, 32'd0);
        idle(1'b0);
        check("r0_cnt", retired_cnt, 32'd3);

        // Stall and flush together: bubble wins
        step(1'b1, 1'b0, 1'b1, 2'b10, 4'd7, 16'h0, 16'h0, 16'h00AA, 1'b1, 1'b1);
        check("sf_we", {31'd0, rf_we}, 32'd0);
        idle(1'b0);
        check("sf_cnt", retired_cnt, 32'd3);

        // Link result select
        step(1'b1, 1'b0, 1'b1, 2'b10, 4'd14, 16'h0, 16'h0, 16'h0102, 1'b0, 1'b0);
        check("link_data", {16'd0, rf_wr_data}, 32'h0102);

        // HLT with reg_wr set: pulse, no write, then frozen
        step(1'b1, 1'b1, 1'b1, 2'b00, 4'd2, 16'h5555, 16'h0, 16'h0, 1'b0, 1'b0);
        check("hlt_pulse", {31'd0, halt_W}, 32'd1);
        check("hlt_we", {31'd0, rf_we}, 32'd0);
        add(4'd4, 16'h4444);
        check("hlt_halted", {31'd0, halted}, 32'd1);
        check("hlt_ignored", {31'd0, rf_we}, 32'd0);
        check("hlt_pulse_gone", {31'd0, halt_W}, 32'd0);
        add(4'd6, 16'h6666);
        check("hlt_cnt", retired_cnt, 32'd5);

        // 17 retirements with a 4-bit counter wrap to 1
        do_reset();
        for (int i = 0; i < 17; i++) add(4'(i % 15 + 1), 16'(i));
        idle(1'b0);
        check("wrap_cnt4", {28'd0, retired_cnt4}, 32'd1);
        check("wrap_cnt32", retired_cnt, 32'd17);

        // Reset in the middle of a stall discards the entry
        add(4'd9, 16'h9999);
        idle(1'b1);
        do_reset();
        idle(1'b1);
        check("post_rst_we", {31'd0, rf_we}, 32'd0);

        // Randomized episodes
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int c = 0; c < 400; c++) begin
                step($urandom_range(3, 0) != 0, $urandom_range(149, 0) == 0,
                     1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom),
                     16'($urandom), 16'($urandom),
                     $urandom_range(9, 0) < 3, $urandom_range(9, 0) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
